acorn_init128: RTL
==================

# acorn_init128

Key/IV initialization stage for the ACORN-128 datapath. Loads a 128-bit key and 128-bit IV, clears the 293-bit LFSR state, and runs the 1792 initialization steps with ca = cb = 1. Presents the resulting state to the downstream encryption stage, which consumes `state_out` as its starting state. Multi-cycle, start/done handshake, selectable unrolling.

## Interface
- UNROLL, 1, state-update steps per clock; legal values 1, 2, 4, 8, 16 (must divide 1792)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- key  in  128  key; bit 0 is K_0, consumed first
- iv  in  128  IV; bit 0 is IV_0
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when the final step has been written
- state_valid  out  1  high from `done` until the next accepted `start` or reset
- state_out  out  293  S[292:0] after step 1791; meaningful only while `state_valid`=1

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE after the final batch.
  - DONE -> RUN on `start`; otherwise DONE holds.
- On an accepted `start`: latch `key` and `iv` into internal registers, clear S to 0, clear step counter t to 0. Input ports are don't-care afterwards.
- Message bit per step t:
  - t = 0..127: K_t
  - t = 128..255: IV_(t-128)
  - t = 256: K_0 ^ 1
  - t = 257..1791: K_(t mod 128)
- One step, with ca = cb = 1, applied in this order:
  - S289 ^= S235^S230
  - S230 ^= S196^S193
  - S193 ^= S160^S154
  - S154 ^= S111^S107
  - S107 ^= S66^S61
  - S61 ^= S23^S0
  - ks = S12 ^ S154 ^ maj(S235,S61,S193) ^ ch(S230,S111,S66)
  - f = S0 ^ ~S107 ^ maj(S244,S23,S160) ^ S196 ^ ks ^ m_t
  - Shift S_j <= S_(j+1) for j = 0..291, then S292 <= f.
  - Definitions: maj(x,y,z) = xy^xz^yz; ch(x,y,z) = xy^(~x)z.
- RUN performs UNROLL chained steps per cycle, using steps t..t+UNROLL-1, then t += UNROLL.
- Counter is 11 bits. The last batch is the one where t == 1792-UNROLL. The counter never wraps in RUN.
- `start` while in RUN is ignored; there is no abort.
- `start` in the same cycle as `done` (DONE state) is accepted. `state_valid` drops on the next edge.

## Timing
- Reset values: busy=0, done=0, state_valid=0, state_out=0, FSM=IDLE, t=0.
- Reset deasserted asynchronously mid-RUN: on return, FSM is IDLE and no `done` is produced.
- Latency: `start` sampled at edge 0; `busy`=1 after edge 0; `done`=1 and `state_valid`=1 after edge N, where N = 1792/UNROLL. `busy`=0 after edge N.
  - N = 1792 for UNROLL=1.
  - N = 224 for UNROLL=8.
- `state_out` is a direct register output, stable while `state_valid`=1. It changes only after the next accepted `start`, when it is cleared to 0.
- Critical path is UNROLL chained steps; UNROLL=16 is a throughput option, not the timing-closure default.

## Structure
- Shared package `acorn_pkg`:
  - STATE_W=293, INIT_STEPS=1792
  - the six tap-index constants
  - FSM enum `init_state_t` {IDLE, RUN, DONE}
  - functions `maj`, `ch`
- Sub-module `acorn_step`: purely combinational single step. Inputs: S[292:0], m, ca, cb. Outputs: S_next[292:0], ks.
  - Instantiated UNROLL times via generate, with ca=cb=1 tied.
  - Shared with later encryption/finalization rework.
- Message-bit mux: indexed select on the latched key/IV by step number, computed per unrolled lane.

## Test plan
- key=0, iv=0, UNROLL=1, start pulse -> busy high 1792 cycles; done single pulse exactly 1792 cycles after start edge; state_out bit-exact with the C reference model (`acorn128_init`).
- key=128'h000102…0F, iv=128'hF0E1…87, UNROLL=8 -> done after exactly 224 cycles; state_out equals the UNROLL=1 result and the C model.
- Boundary step: key with K_0=1 vs K_0=0, all else 0 -> state_out matches model; confirms the m_256 = K_0^1 bit.
- start re-pulsed at cycles 5 and 1000 during RUN; key/iv ports changed after cycle 0 -> ignored; single done at 1792; result from original key/iv.
- rst_n low at cycle 900 of RUN, then new start -> all outputs 0 during reset; next run completes in a full 1792 cycles with correct state.
- start held high through done -> done pulse, then immediate new RUN; state_valid high for exactly one cycle; second result correct.

Source files
------------

// File: rtl/acorn_pkg.sv
// Shared constants, FSM encoding and boolean helpers for the ACORN-128 datapath.
package acorn_pkg;

  localparam int unsigned STATE_W    = 293;
  localparam int unsigned INIT_STEPS = 1792;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned CNT_W      = 11;

  // Feedback positions updated (in this order) at the start of every step
  localparam int unsigned FB_A = 289;
  localparam int unsigned FB_B = 230;
  localparam int unsigned FB_C = 193;
  localparam int unsigned FB_D = 154;
  localparam int unsigned FB_E = 107;
  localparam int unsigned FB_F = 61;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } init_state_t;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // Init message bit for a step: IV during steps 128..255, key otherwise, with the
  // key bit inverted at step 256 (the single padding '1').
  function automatic logic msg_bit(input logic [KEY_W-1:0] key,
                                   input logic [KEY_W-1:0] iv,
                                   input logic [CNT_W-1:0] step);
    logic w_iv_phase;
    logic w_pad;
    w_iv_phase = (step[CNT_W-1:7] == 4'd1);
    w_pad      = (step == CNT_W'(256));
    return (w_iv_phase ? iv[step[6:0]] : key[step[6:0]]) ^ w_pad;
  endfunction

endpackage

// File: rtl/acorn_step.sv
// One combinational ACORN-128 state-update step; reused by encryption/finalization.
module acorn_step
  import acorn_pkg::*;
(
  input  logic [STATE_W-1:0] i_s,
  input  logic               i_m,
  input  logic               i_ca,
  input  logic               i_cb,
  output logic [STATE_W-1:0] o_s_next,
  output logic               o_ks
);

  logic [STATE_W-1:0] w_u;
  logic               w_f;

  // Sequential in-place feedback updates, keystream, feedback bit, then shift
  always_comb begin
    w_u       = i_s;
    w_u[FB_A] = w_u[FB_A] ^ w_u[235] ^ w_u[FB_B];
    w_u[FB_B] = w_u[FB_B] ^ w_u[196] ^ w_u[FB_C];
    w_u[FB_C] = w_u[FB_C] ^ w_u[160] ^ w_u[FB_D];
    w_u[FB_D] = w_u[FB_D] ^ w_u[111] ^ w_u[FB_E];
    w_u[FB_E] = w_u[FB_E] ^ w_u[66]  ^ w_u[FB_F];
    w_u[FB_F] = w_u[FB_F] ^ w_u[23]  ^ w_u[0];
    o_ks      = w_u[12] ^ w_u[FB_D]
              ^ maj(w_u[235], w_u[FB_F], w_u[FB_C])
              ^ ch(w_u[FB_B], w_u[111], w_u[66]);
    w_f       = w_u[0] ^ ~w_u[FB_E] ^ maj(w_u[244], w_u[23], w_u[160])
              ^ (i_ca & w_u[196]) ^ (i_cb & o_ks) ^ i_m;
    o_s_next  = {w_f, w_u[STATE_W-1:1]};
  end

endmodule

// File: rtl/acorn_init128.sv
// ACORN-128 key/IV initialization: 1792 steps, UNROLL steps per clock.
module acorn_init128
  import acorn_pkg::*;
#(
  parameter int unsigned UNROLL = 1  // 1, 2, 4, 8 or 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [KEY_W-1:0]   iv,
  output logic               busy,
  output logic               done,
  output logic               state_valid,
  output logic [STATE_W-1:0] state_out
);

  localparam int unsigned LAST_T = INIT_STEPS - UNROLL;

  init_state_t        r_state;
  init_state_t        w_state_nxt;
  logic               r_busy;
  logic               r_done;
  logic               r_valid;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_valid_nxt;
  logic               w_load;
  logic               w_last;

  logic [KEY_W-1:0]   r_key;
  logic [KEY_W-1:0]   r_iv;
  logic [CNT_W-1:0]   r_t;
  logic [STATE_W-1:0] r_s;

  logic [STATE_W-1:0] w_chain [UNROLL+1];
  logic [UNROLL-1:0]  w_ks_unused;

  assign w_last = (r_t == CNT_W'(LAST_T));
  assign w_load = start && (r_state != RUN);

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (start)  w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered handshake outputs
  always_comb begin
    w_busy_nxt  = (w_state_nxt == RUN);
    w_done_nxt  = (r_state == RUN) && w_last;
    w_valid_nxt = (w_state_nxt == DONE);
  end

  // UNROLL chained steps, each with its own message bit
  assign w_chain[0] = r_s;
  for (genvar l = 0; l < UNROLL; l++) begin : g_lane
    logic w_m;
    assign w_m = msg_bit(r_key, r_iv, r_t + CNT_W'(l));
    acorn_step u_step (
      .i_s      (w_chain[l]),
      .i_m      (w_m),
      .i_ca     (1'b1),
      .i_cb     (1'b1),
      .o_s_next (w_chain[l+1]),
      .o_ks     (w_ks_unused[l])
    );
  end

  // Datapath: latch key/IV and clear on accepted start, advance one batch per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
      r_iv  <= '0;
      r_t   <= '0;
      r_s   <= '0;
    end else if (w_load) begin
      r_key <= key;
      r_iv  <= iv;
      r_t   <= '0;
      r_s   <= '0;
    end else if (r_state == RUN) begin
      r_t   <= r_t + CNT_W'(UNROLL);
      r_s   <= w_chain[UNROLL];
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign state_valid = r_valid;
  assign state_out   = r_s;

endmodule
